// File: rtl/deinterleaver_buf.sv
// deinterleaver_buf: 802.11a RX block deinterleaver. Buffers one OFDM symbol of subcarrier words and
// streams its coded bits in pre-interleave order. Define DEINTLV_PINGPONG_EN for a second buffer bank.
module deinterleaver_buf #(
    parameter int NSC     = 48,
    parameter int MAXBPSC = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [MAXBPSC-1:0] sym_data,
    input  logic [2:0]         bpsc,
    input  logic               clear,
    output logic               bit_valid,
    input  logic               bit_ready,
    output logic               bit_data,
    output logic               bit_last,
    output logic               cfg_err,
    output logic               busy
);
    localparam int NB   = NSC * MAXBPSC;
    localparam int ROWF = NSC / 16;
    localparam int AW   = $clog2(NB);
    localparam int W    = $clog2(2 * NB);
    localparam int SCW  = $clog2(NSC);
`ifdef DEINTLV_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    typedef enum logic {FILL, DRAIN} bank_st_t;

    bank_st_t       st    [2];
    logic [2:0]     lbpsc [2];
    logic [NB-1:0]  mem   [2];
    logic           wbank, rbank;
    logic [SCW-1:0] sc;
    logic [AW-1:0]  k;

    logic           bp_bad, acc, xfer;
    logic [2:0]     bp_in, bp_w, bp_r;
    logic [AW-1:0]  wbase, rj;
    logic [NB-1:0]  wnext;
    logic [W-1:0]   ncbps, ri, rt, rjw;
    logic [1:0]     im, tm;
    logic [3:0]     k4;

    // Bank pointers stay at 0 in the single-bank build, so bank 1 is never used.
    assign sym_ready = (st[wbank] == FILL);
    assign bit_valid = (st[rbank] == DRAIN);
    assign acc       = sym_valid && sym_ready && !reset && !clear;
    assign xfer      = bit_valid && bit_ready && !reset && !clear;
    assign cfg_err   = acc && (sc == '0) && bp_bad;
    assign busy      = (sc != '0) || (st[0] == DRAIN) || (st[1] == DRAIN);

    always_comb begin
        bp_bad = !(bpsc == 3'd1 || bpsc == 3'd2 || bpsc == 3'd4 || bpsc == 3'd6);
        bp_in  = bp_bad ? 3'd1 : bpsc;
        bp_w   = (sc == '0) ? bp_in : lbpsc[wbank];
        wbase  = AW'(W'(bp_w) * W'(sc));
        wnext  = mem[wbank];
        for (int b = 0; b < MAXBPSC; b++)
            if (3'(b) < bp_w) wnext[wbase + AW'(b)] = sym_data[b];
    end

    // floor(i/s)*s is formed as i - (i mod s); the row index floor(16i/NCBPS) is simply k[3:0].
    always_comb begin
        bp_r  = lbpsc[rbank];
        k4    = k[3:0];
        ncbps = W'(NSC) * W'(bp_r);
        ri    = W'(ROWF) * W'(bp_r) * W'(k4) + W'(k >> 4);
        rt    = ri + ncbps - W'(k4);
        im    = '0;
        tm    = '0;
        case (bp_r)
            3'd6: begin
                im = 2'(ri % W'(3));
                tm = 2'(rt % W'(3));
            end
            3'd4: begin
                im = {1'b0, ri[0]};
                tm = {1'b0, rt[0]};
            end
            default: ;
        endcase
        rjw = ri - W'(im) + W'(tm);
        rj  = AW'(rjw);
    end

    assign bit_data = bit_valid && mem[rbank][rj];
    assign bit_last = bit_valid && (W'(k) == ncbps - W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            st[0]    <= FILL;
            st[1]    <= FILL;
            lbpsc[0] <= 3'd1;
            lbpsc[1] <= 3'd1;
            wbank    <= 1'b0;
            rbank    <= 1'b0;
            sc       <= '0;
            k        <= '0;
        end else begin
            if (acc) begin
                if (sc == '0) lbpsc[wbank] <= bp_in;
                if (sc == SCW'(NSC - 1)) begin
                    sc        <= '0;
                    st[wbank] <= DRAIN;
                    wbank     <= wbank ^ PP;
                end else begin
                    sc <= sc + 1'b1;
                end
            end
            if (xfer) begin
                if (bit_last) begin
                    k         <= '0;
                    st[rbank] <= FILL;
                    rbank     <= rbank ^ PP;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end

    // Storage is not reset: every index below NCBPS is rewritten before a bank drains.
    always_ff @(posedge clk) begin
        if (acc) mem[wbank] <= wnext;
    end
endmodule

// File: tb/tb_deinterleaver_buf.sv
// tb_deinterleaver_buf: randomized and directed checks of deinterleaver_buf against a division-based
// model of the 802.11a interleaver permutation; honours DEINTLV_PINGPONG_EN.
`timescale 1ns/1ps
module tb_deinterleaver_buf;
    localparam int NSC = 48;

    logic       clk = 1'b0, reset = 1'b1, sym_valid = 1'b0, clear = 1'b0, bit_ready = 1'b0;
    logic [5:0] sym_data = '0;
    logic [2:0] bpsc = 3'd1;
    logic       sym_ready, bit_valid, bit_data, bit_last, cfg_err, busy;

    always #5 clk = ~clk;

    deinterleaver_buf #(.NSC(NSC), .MAXBPSC(6)) dut (
        .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_data(sym_data), .bpsc(bpsc), .clear(clear), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .bit_data(bit_data), .bit_last(bit_last),
        .cfg_err(cfg_err), .busy(busy)
    );

    int checks = 0, errors = 0;
    logic [1:0] expq [$];
    logic [5:0] words [NSC];
    int rdy_mode = 0;
    int sym_pos = 0, hi_cnt = 0, hi_idx = -1;
    int last_nbits = 0, last_hi_cnt = 0, last_hi_idx = -1;
    int cfg_pulses = 0, xfer_total = 0, first_cyc = 0, last_cyc = 0, cyc = 0, hold_cnt = 0;
    bit rdy_in_drain = 1'b0;
    logic prev_stall = 1'b0, prev_d = 1'b0, prev_l = 1'b0;
    logic [1:0] e;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Forward interleaver k -> j written with plain divisions; output k must equal buffered bit j.
    function automatic void model_push(input int bp);
        int ncbps, s, i, j;
        logic [5:0] w;
        ncbps = NSC * bp;
        s = (bp / 2 > 1) ? bp / 2 : 1;
        for (int kk = 0; kk < ncbps; kk++) begin
            i = (ncbps / 16) * (kk % 16) + kk / 16;
            j = s * (i / s) + (i + ncbps - (16 * i) / ncbps) % s;
            w = words[j / bp];
            expq.push_back({w[j % bp], (kk == ncbps - 1) ? 1'b1 : 1'b0});
        end
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bit_ready = 1'b1;
            1:       bit_ready = 1'($urandom_range(0, 1));
            default: bit_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        cyc++;
        if (cfg_err) cfg_pulses++;
        if (bit_valid && sym_ready) rdy_in_drain = 1'b1;
        if (bit_valid) begin
            if (prev_stall) begin
                hold_cnt++;
                chk("hold_data", int'(bit_data), int'(prev_d));
                chk("hold_last", int'(bit_last), int'(prev_l));
            end
            if (bit_ready && !clear) begin
                if (expq.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("bit_data", int'(bit_data), int'(e[1]));
                    chk("bit_last", int'(bit_last), int'(e[0]));
                end
                if (xfer_total == 0) first_cyc = cyc;
                last_cyc = cyc;
                xfer_total++;
                if (bit_data) begin hi_cnt++; hi_idx = sym_pos; end
                sym_pos++;
                if (bit_last) begin
                    last_nbits = sym_pos; last_hi_cnt = hi_cnt; last_hi_idx = hi_idx;
                    sym_pos = 0; hi_cnt = 0; hi_idx = -1;
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = !bit_ready;
                prev_d = bit_data;
                prev_l = bit_last;
            end
        end else begin
            if (prev_stall) chk("hold_valid", 0, 1);
            prev_stall = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word was accepted.
    task automatic put_word(input logic [2:0] bp, input logic [5:0] d);
        int n = 0;
        sym_valid = 1'b1; bpsc = bp; sym_data = d;
        @(negedge clk);
        while (!sym_ready && n < 5000) begin @(negedge clk); n++; end
        if (!sym_ready) chk("sym_ready_timeout", 0, 1);
        @(posedge clk); #1;
        sym_valid = 1'b0;
    endtask

    task automatic send_sym(input logic [2:0] bp0, input bit chg, input bit gaps);
        logic [2:0] bl, b;
        bl = (bp0 == 3'd1 || bp0 == 3'd2 || bp0 == 3'd4 || bp0 == 3'd6) ? bp0 : 3'd1;
        for (int s = 0; s < NSC; s++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            b = (s != 0 && chg) ? 3'($urandom_range(0, 7)) : bp0;
            put_word(b, words[s]);
        end
        model_push(int'(bl));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((expq.size() != 0 || bit_valid) && n < 6000) begin @(posedge clk); #1; n++; end
        if (n >= 6000) chk("drain_timeout", 0, 1);
    endtask

    task automatic fill_words(input bit rnd);
        for (int s = 0; s < NSC; s++) words[s] = rnd ? 6'($urandom) : 6'd0;
    endtask

    function automatic logic [2:0] rnd_bp();
        logic [2:0] t [4];
        t[0] = 3'd1; t[1] = 3'd2; t[2] = 3'd4; t[3] = 3'd6;
        return t[$urandom_range(0, 3)];
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_sym_ready", int'(sym_ready), 1);
        chk("rst_bit_valid", int'(bit_valid), 0);
        chk("rst_bit_data", int'(bit_data), 0);
        chk("rst_bit_last", int'(bit_last), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk); #1;

        // single hot bits in known positions
        fill_words(0); words[3] = 6'd1;
        send_sym(3'd1, 0, 0);
        chk("t1_latency_valid", int'(bit_valid), 1);
        chk("t1_busy", int'(busy), 1);
        wait_drain();
        chk("t1_nbits", last_nbits, 48);
        chk("t1_hi_cnt", last_hi_cnt, 1);
        chk("t1_hi_idx", last_hi_idx, 1);
        chk("t1_idle_busy", int'(busy), 0);

        fill_words(0); words[0] = 6'b000010;
        send_sym(3'd4, 0, 0); wait_drain();
        chk("t2a_nbits", last_nbits, 192);
        chk("t2a_hi_cnt", last_hi_cnt, 1);
        chk("t2a_hi_idx", last_hi_idx, 16);
        fill_words(0); words[3] = 6'b000010;
        send_sym(3'd4, 0, 0); wait_drain();
        chk("t2b_hi_idx", last_hi_idx, 1);

        fill_words(0); words[3] = 6'b000100;
        send_sym(3'd6, 0, 0); wait_drain();
        chk("t3a_nbits", last_nbits, 288);
        chk("t3a_hi_cnt", last_hi_cnt, 1);
        chk("t3a_hi_idx", last_hi_idx, 1);
        fill_words(0); words[3] = 6'b000001;
        send_sym(3'd2, 0, 0); wait_drain();
        chk("t3b_nbits", last_nbits, 96);
        chk("t3b_hi_idx", last_hi_idx, 1);

        // backpressure hold in mid-drain
        fill_words(1);
        send_sym(3'd4, 0, 0);
        n = 0;
        while (sym_pos < 60 && n < 1000) begin @(posedge clk); #1; n++; end
        hold_cnt = 0;
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        #1 rdy_mode = 0;
        wait_drain();
        chk("t4_stall_held", int'(hold_cnt >= 4), 1);
        chk("t4_nbits", last_nbits, 192);

        // abort at k=20
        fill_words(1);
        send_sym(3'd1, 0, 0);
        n = 0;
        while (sym_pos != 20 && n < 1000) begin @(posedge clk); #1; n++; end
        chk("t5_reached_k20", sym_pos, 20);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        expq.delete(); sym_pos = 0; hi_cnt = 0; hi_idx = -1;
        @(negedge clk);
        chk("t5_clr_bit_valid", int'(bit_valid), 0);
        chk("t5_clr_sym_ready", int'(sym_ready), 1);
        chk("t5_clr_busy", int'(busy), 0);
        @(posedge clk); #1;
        fill_words(1);
        send_sym(3'd6, 0, 0); wait_drain();
        chk("t5_post_nbits", last_nbits, 288);
        c0 = cfg_pulses;
        fill_words(1);
        send_sym(3'd3, 0, 0); wait_drain();
        chk("t5_cfg_pulses", cfg_pulses - c0, 1);
        chk("t5_cfg_nbits", last_nbits, 48);

        // two bpsc=6 symbols back to back
        xfer_total = 0; rdy_in_drain = 1'b0;
        fill_words(1); send_sym(3'd6, 0, 0);
        fill_words(1); send_sym(3'd6, 0, 0);
        wait_drain();
        chk("t6_total_bits", xfer_total, 576);
`ifdef DEINTLV_PINGPONG_EN
        chk("t6_span_no_gap", last_cyc - first_cyc + 1, 576);
        chk("t6_ready_in_drain", int'(rdy_in_drain), 1);
`endif

        // random symbols, random bpsc changes mid-symbol, random gaps and backpressure
        c0 = cfg_pulses;
        rdy_mode = 1;
        for (int t = 0; t < 8; t++) begin
            fill_words(1);
            send_sym(rnd_bp(), 1, 1);
        end
        wait_drain();
        rdy_mode = 0;
        chk("rnd_cfg_none", cfg_pulses - c0, 0);
        chk("rnd_queue_empty", expq.size(), 0);
`ifndef DEINTLV_PINGPONG_EN
        chk("single_no_ready_in_drain", int'(rdy_in_drain), 0);
`endif
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
